// File: rtl/deserializador_if.sv
// Serial-in / parallel-out bus for deserializador: two bit lines with a
// valid qualifier on the source side, and a valid/ready word port with status.
interface deserializador_if #(
  parameter int N = 9
);
  logic         A;
  logic         B;
  logic         in_valid;
  logic         out_ready;
  logic [N-1:0] word_a;
  logic [N-1:0] word_b;
  logic [N-1:0] word_and;
  logic         out_valid;
  logic         busy;
  logic [3:0]   bit_count;
  logic         overrun;

  // Drives the serial lines and the consumer's ready.
  modport master (
    output A, B, in_valid, out_ready,
    input  word_a, word_b, word_and, out_valid, busy, bit_count, overrun
  );

  // The receiver itself.
  modport slave (
    input  A, B, in_valid, out_ready,
    output word_a, word_b, word_and, out_valid, busy, bit_count, overrun
  );
endinterface

// File: rtl/deserializador.sv
// Two-line LSB-first serial-to-parallel receiver: assembles N qualified bits
// per line, presents both words and their AND over a valid/ready handshake.
module deserializador #(
  parameter int N = 9
) (
  input  logic            clk,
  input  logic            reset,
  deserializador_if.slave bus
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("deserializador: N must be in 2..16");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t       state_q, state_nxt;
  logic [3:0]   count_q, count_nxt;
  logic [N-1:0] sh_a_q, sh_a_nxt;
  logic [N-1:0] sh_b_q, sh_b_nxt;
  logic [N-1:0] word_a_q, word_b_q, word_and_q;
  logic         out_valid_q, out_valid_nxt;
  logic         overrun_q;
  logic         complete;
  logic         out_free;
  logic         load;
  logic         drop;

  // NOTE: every signal assigned here gets a default first so that no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    sh_a_nxt  = sh_a_q;
    sh_b_nxt  = sh_b_q;
    complete  = 1'b0;

    if (bus.in_valid) begin
      for (int i = 0; i < N; i++) begin
        if (count_q == 4'(i)) begin
          sh_a_nxt[i] = bus.A;
          sh_b_nxt[i] = bus.B;
        end
      end

      unique case (state_q)
        IDLE: begin
          count_nxt = 4'd1;
          state_nxt = SHIFT;
        end
        SHIFT: begin
          if (count_q == LAST) begin
            complete  = 1'b1;
            count_nxt = 4'd0;
            state_nxt = IDLE;
          end else begin
            count_nxt = count_q + 4'd1;
          end
        end
        default: begin
          count_nxt = 4'd0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // A word finishing on the same edge the consumer takes the old one is not
  // an overrun: the output slot frees up exactly as the new word arrives.
  always_comb begin
    out_free      = !out_valid_q || bus.out_ready;
    load          = complete && out_free;
    drop          = complete && !out_free;
    out_valid_nxt = out_valid_q;
    if (load) begin
      out_valid_nxt = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
    end
  end

  // NOTE: the shift and word registers are plain flops, not a memory array,
  // so clearing them on reset is cheap and gives downstream a defined zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a_q <= '0;
      sh_b_q <= '0;
    end else begin
      sh_a_q <= sh_a_nxt;
      sh_b_q <= sh_b_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_a_q    <= '0;
      word_b_q    <= '0;
      word_and_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_nxt;
      if (load) begin
        word_a_q   <= sh_a_nxt;
        word_b_q   <= sh_b_nxt;
        word_and_q <= sh_a_nxt & sh_b_nxt;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.word_a    = word_a_q;
  assign bus.word_b    = word_b_q;
  assign bus.word_and  = word_and_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.bit_count = count_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_deserializador.sv
// Directed bench for deserializador (N=9): basic word, gaps, back-to-back,
// overrun, asynchronous reset mid-word and completion during transfer.
module tb_deserializador;

  localparam int N = 9;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  deserializador_if #(.N(N)) bus ();

  deserializador #(.N(N)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one bit pair, let one edge pass, return 1 time unit after it.
  task automatic send_bit(input logic a, input logic b);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [N-1:0] wa, input logic [N-1:0] wb,
                           input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_bit(wa[i], wb[i]);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [N-1:0] ea,
                            input logic [N-1:0] eb, input logic ev,
                            input logic eo);
    check({tag, ".word_a"},    32'(bus.word_a),    32'(ea));
    check({tag, ".word_b"},    32'(bus.word_b),    32'(eb));
    check({tag, ".word_and"},  32'(bus.word_and),  32'(ea & eb));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    check({tag, ".overrun"},   32'(bus.overrun),   32'(eo));
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.A         = 1'b0;
    bus.B         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check_word("reset", 9'h000, 9'h000, 1'b0, 1'b0);
    check("reset.busy",      32'(bus.busy),      32'd0);
    check("reset.bit_count", 32'(bus.bit_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic word
    send_bits(9'h0EE, 9'h044, 0, 0);
    check("basic.busy1",  32'(bus.busy),      32'd1);
    check("basic.count1", 32'(bus.bit_count), 32'd1);
    send_bits(9'h0EE, 9'h044, 1, 8);
    check_word("basic", 9'h0EE, 9'h044, 1'b1, 1'b0);
    check("basic.busy",  32'(bus.busy),      32'd0);
    check("basic.count", 32'(bus.bit_count), 32'd0);
    consume();
    check("basic.consumed", 32'(bus.out_valid), 32'd0);

    // Gaps mid-word
    send_bits(9'h0EE, 9'h044, 0, 4);
    for (int g = 0; g < 3; g++) begin
      check("gap.count", 32'(bus.bit_count), 32'd5);
      check("gap.busy",  32'(bus.busy),      32'd1);
      idle_cycle();
    end
    check("gap.count_end", 32'(bus.bit_count), 32'd5);
    check("gap.no_valid",  32'(bus.out_valid), 32'd0);
    send_bits(9'h0EE, 9'h044, 5, 8);
    check_word("gap", 9'h0EE, 9'h044, 1'b1, 1'b0);
    consume();

    // Back-to-back with ready held high
    bus.out_ready = 1'b1;
    send_bits(9'h0EE, 9'h044, 0, 8);
    check_word("b2b.w1", 9'h0EE, 9'h044, 1'b1, 1'b0);
    send_bits(9'h155, 9'h0AA, 0, 7);
    check("b2b.count8", 32'(bus.bit_count), 32'd8);
    check("b2b.hold_a", 32'(bus.word_a),    32'h0EE);
    send_bits(9'h155, 9'h0AA, 8, 8);
    bus.out_ready = 1'b0;
    check_word("b2b.w2", 9'h155, 9'h0AA, 1'b1, 1'b0);
    check("b2b.count", 32'(bus.bit_count), 32'd0);
    consume();
    check("b2b.consumed", 32'(bus.out_valid), 32'd0);

    // Overrun
    send_bits(9'h0EE, 9'h044, 0, 8);
    check_word("ovr.w1", 9'h0EE, 9'h044, 1'b1, 1'b0);
    send_bits(9'h155, 9'h0AA, 0, 8);
    check_word("ovr.w2", 9'h0EE, 9'h044, 1'b1, 1'b1);
    consume();
    check("ovr.consumed", 32'(bus.out_valid), 32'd0);
    check("ovr.sticky",   32'(bus.overrun),   32'd1);

    // Asynchronous reset mid-word
    send_bits(9'h155, 9'h0AA, 0, 4);
    check("rst.count5", 32'(bus.bit_count), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check_word("rst.async", 9'h000, 9'h000, 1'b0, 1'b0);
    check("rst.busy",  32'(bus.busy),      32'd0);
    check("rst.count", 32'(bus.bit_count), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst.idle_count", 32'(bus.bit_count), 32'd0);
    send_bits(9'h0EE, 9'h044, 0, 8);
    check_word("rst.new", 9'h0EE, 9'h044, 1'b1, 1'b0);

    // Completion on the same edge as a transfer
    send_bits(9'h155, 9'h0AA, 0, 7);
    check("cdt.hold_a",    32'(bus.word_a),    32'h0EE);
    check("cdt.valid_pre", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    send_bits(9'h155, 9'h0AA, 8, 8);
    bus.out_ready = 1'b0;
    check_word("cdt", 9'h155, 9'h0AA, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
